// File: rtl/memarb_nch_if.sv
// Client and DRAM-side signal bundle for the memarb_nch arbiter.
interface memarb_nch_if #(
    parameter int unsigned NCH = 3,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 72
);
    // client side
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH*2-1:0]  wmode;
    logic [NCH-1:0]    gnt;
    logic [NCH-1:0]    rvalid;
    logic [DW-1:0]     rdata;

    // memory side
    logic              mem_en;
    logic              mem_rw;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [1:0]        mem_mode;
    logic [DW-1:0]     mem_rdata;

    // clients plus memory model
    modport master (
        output req, we, addr, wdata, wmode, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_rw, mem_addr, mem_wdata, mem_mode
    );

    // arbiter
    modport slave (
        input  req, we, addr, wdata, wmode, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_rw, mem_addr, mem_wdata, mem_mode
    );
endinterface

// File: rtl/memarb_nch.sv
// NCH-channel single-port DRAM arbiter: channel 0 has priority under a burst
// cap, channels 1..NCH-1 share round-robin. One access in flight at a time.
module memarb_nch #(
    parameter int unsigned NCH       = 3,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 72,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    memarb_nch_if.slave bus
);

    localparam int unsigned   CW        = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0]    LAT_LAST  = 4'(RD_LAT);
    localparam logic [3:0]    BURST_CAP = 4'(MAX_BURST);
    localparam logic [CW-1:0] RR_INIT   = CW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;

    logic [CW-1:0]   win_q, win_d;
    logic [CW-1:0]   last_rr_q, last_rr_d;
    logic [3:0]      burst_q, burst_d;
    logic [3:0]      lat_q, lat_d;

    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [NCH-1:0]  rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_rw_q, mem_rw_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]      mem_mode_q, mem_mode_d;

    logic [CW-1:0]   rr_win_c;
    logic [CW-1:0]   arb_win_c;
    logic            rr_hit_c;
    logic            others_c;
    logic            pick0_c;
    logic            any_c;

    // k-th candidate after last in the ring 1..NCH-1 (last is never 0)
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] last, input int unsigned k);
        int unsigned t;
        t = ((32'(last) + k - 1) % (NCH - 1)) + 1;
        return CW'(t);
    endfunction

    // round-robin search over channels 1..NCH-1 starting after last_rr
    always_comb begin
        rr_hit_c = 1'b0;
        rr_win_c = last_rr_q;
        for (int unsigned k = 1; k < NCH; k++) begin
            if (!rr_hit_c && bus.req[rr_idx(last_rr_q, k)]) begin
                rr_hit_c = 1'b1;
                rr_win_c = rr_idx(last_rr_q, k);
            end
        end
    end

    // channel 0 wins unless it has used up its burst while others wait
    always_comb begin
        others_c  = |bus.req[NCH-1:1];
        any_c     = |bus.req;
        pick0_c   = bus.req[0] && ((burst_q < BURST_CAP) || !others_c);
        arb_win_c = pick0_c ? '0 : rr_win_c;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; a read is flagged by mem_rw_q while in ISSUE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_c) state_d = ISSUE;
            ISSUE:   state_d = mem_rw_q ? RDWAIT : IDLE;
            RDWAIT:  if (lat_q == LAT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // output and datapath next values; strobes default low, the rest hold
    always_comb begin
        win_d       = win_q;
        last_rr_d   = last_rr_q;
        burst_d     = burst_q;
        lat_d       = lat_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mode_d  = mem_mode_q;

        case (state_q)
            IDLE: begin
                if (!bus.req[0]) begin
                    burst_d = '0;
                end
                if (any_c) begin
                    win_d       = arb_win_c;
                    gnt_d       = NCH'(1) << arb_win_c;
                    mem_en_d    = 1'b1;
                    mem_rw_d    = ~bus.we[arb_win_c];
                    mem_addr_d  = bus.addr[32'(arb_win_c) * AW +: AW];
                    mem_wdata_d = bus.wdata[32'(arb_win_c) * DW +: DW];
                    mem_mode_d  = bus.wmode[32'(arb_win_c) * 2 +: 2];
                    if (arb_win_c == '0) begin
                        if (others_c && (burst_q < BURST_CAP)) begin
                            burst_d = burst_q + 4'd1;
                        end
                    end else begin
                        burst_d   = '0;
                        last_rr_d = arb_win_c;
                    end
                end
            end
            ISSUE: begin
                lat_d = 4'd1;
            end
            RDWAIT: begin
                lat_d = lat_q + 4'd1;
                if (lat_q == LAT_LAST) begin
                    rdata_d  = bus.mem_rdata;
                    rvalid_d = NCH'(1) << win_q;
                end
            end
            default: ;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q       <= '0;
            last_rr_q   <= RR_INIT;
            burst_q     <= '0;
            lat_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mode_q  <= '0;
        end else begin
            win_q       <= win_d;
            last_rr_q   <= last_rr_d;
            burst_q     <= burst_d;
            lat_q       <= lat_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mode_q  <= mem_mode_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mode  = mem_mode_q;

endmodule

// File: doc/memarb_nch.md
Name: memarb_nch

Overview:
- Parametrised DRAM access arbiter. Generalises the two-port VGA/cache memory controller to NCH client channels with configurable address width, data width and read latency.
- Channel 0 is the priority (display) channel. Channels 1..NCH-1 share access round-robin.
- A burst cap stops channel 0 from starving the other channels.
- Sits between the display controller, cache and peripherals and the single-port DRAM/BRAM interface. One access is in flight at a time.

Parameters:
- NCH, 3, number of client channels (2..8); channel 0 is priority.
- AW, 32, address width.
- DW, 72, data width.
- RD_LAT, 2, DRAM read latency in cycles from mem_en to valid mem_rdata (1..15).
- MAX_BURST, 4, maximum consecutive channel-0 grants while any other channel is requesting (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NCH  per-channel request, held high until gnt.
- we  in  NCH  per-channel write enable (1 = write).
- addr  in  NCH*AW  packed addresses; channel i at [i*AW +: AW].
- wdata  in  NCH*DW  packed write data.
- wmode  in  NCH*2  packed access mode: 00 byte, 01 halfword, 10 word, 11 neighborhood.
- gnt  out  NCH  one-hot single-cycle grant.
- rvalid  out  NCH  one-hot single-cycle read-data-valid.
- rdata  out  DW  shared read data, qualified by rvalid.
- mem_en  out  1  DRAM access strobe.
- mem_rw  out  1  DRAM direction; low = write.
- mem_addr  out  AW  DRAM address.
- mem_wdata  out  DW  DRAM write data.
- mem_mode  out  2  DRAM access mode.
- mem_rdata  in  DW  DRAM read data.

Behaviour:
- Reset (rst low, asynchronous):
  - State, counters and registers clear. state=IDLE, gnt=0, rvalid=0, rdata=0.
  - mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0, mem_mode=0.
  - last_rr=NCH-1, burst_cnt=0.
  - Any in-flight read is abandoned; no rvalid is issued after reset releases.
- State machine: IDLE, ISSUE, RDWAIT.
- IDLE, cycle T. Arbitration over req:
  - Channel 0 wins if req[0] and (burst_cnt<MAX_BURST or no other req).
  - Otherwise the winner is the first requesting channel in 1..NCH-1 after last_rr, wrapping from NCH-1 to 1.
  - The winner's addr, we, wdata and wmode are registered. Next state is ISSUE.
  - With no req, remain in IDLE.
- ISSUE, cycle T+1:
  - gnt[winner]=1 for exactly one cycle.
  - mem_en=1, with mem_rw=~we and the latched addr, wdata and mode driven.
  - Write: next state is IDLE. The write is complete; the minimum write spacing is 2 cycles.
  - Read: next state is RDWAIT with lat_cnt=1.
- RDWAIT:
  - mem_en=0, while mem_addr and mem_mode hold.
  - lat_cnt increments each cycle.
  - When lat_cnt==RD_LAT, mem_rdata is captured into rdata and the state returns to IDLE.
  - rvalid[winner]=1 in the following cycle, T+2+RD_LAT. Arbitration in that same IDLE cycle proceeds normally.
  - rdata holds until the next read capture.
- Burst counter:
  - Increments on each channel-0 grant while any req[1..] is high, saturating at MAX_BURST.
  - Clears on any non-zero grant, and in any IDLE cycle where req[0]=0.
- last_rr updates only on a non-zero grant.
- Client rule: req, addr, we, wdata and wmode are stable from req rise until gnt. Inputs seen during ISSUE and RDWAIT are ignored.
  - A client sees gnt and either drops req or presents its next request the following cycle.
- Simultaneous events:
  - All channels requesting: with burst_cnt<MAX_BURST, channel 0 wins; otherwise the round-robin winner wins.
  - rvalid and a new grant decision may coincide.
- Invariants: gnt and rvalid are never multi-hot. A channel never sees gnt and rvalid for the same read in the same cycle.

Test Plan:
- Reset mid-RDWAIT (RD_LAT=2, channel 1 read issued): pull rst low in RDWAIT. All outputs go to 0 immediately (mem_rw=1), and no rvalid ever follows.
- Single read, channel 1, addr=0x40, mem_rdata=0xAB at the sampling cycle. Required: gnt[1] at T+1; mem_en=1, mem_rw=1, mem_addr=0x40 at T+1; rvalid[1] and rdata=0xAB at T+4.
- Single write, channel 2, addr=0x10, wdata=0x5A, wmode=00. Required: gnt[2] and mem_en=1, mem_rw=0, mem_wdata=0x5A, mem_mode=00 at T+1; IDLE at T+2; no rvalid.
- Round-robin: channels 1 and 2 issue continuous writes with req[0]=0. Required grant order is 1,2,1,2, with grants every 2 cycles.
- Burst cap (MAX_BURST=4): req[0] and req[1] continuously high, all writes. Required grant order is 0,0,0,0,1,0,0,0,0,1.
- Priority without contention: only req[0], 10 reads back-to-back. All 10 are granted to channel 0, and each rvalid[0] arrives RD_LAT+1 cycles after its gnt.
